// File: rtl/ad9280_sample_packer.sv
// AD9280 capture packer: four samples per 32-bit AXIS word (first byte in [31:24]), byte-count length, tlast/partial tkeep on the final beat.
// Latency: tvalid two cycles after a word's last byte is captured. Backpressure: an internal FIFO absorbs stalls; a full FIFO drops the word and sets sticky overflow.

module ad9280_sample_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  output logic          full
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign rd_vld = (cnt != '0);
  assign full   = cnt[AW];
  assign do_rd  = rd_rdy & rd_vld;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

module ad9280_sample_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        adc_clk,
  input  logic        adc_rst,
  input  logic [7:0]  adc_data,
  input  logic        sample_start,
  input  logic [31:0] sample_len,
  output logic        st_clr,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);
  typedef enum logic [1:0] {IDLE, SAMPLE, FLUSH} state_t;
  state_t state, state_nxt;

  logic        start_q, start_edge, accept;
  logic [31:0] len_q, byte_cnt, acc_q, word_nxt;
  logic [3:0]  keep_nxt;
  logic        last_byte;
  logic        push_q, pend_last;
  logic [36:0] push_dat_q, fifo_wr_dat, fifo_rd_dat;
  logic        fifo_wr, fifo_full, fifo_rd_vld, pop, drop;

  assign start_edge  = sample_start & ~start_q;
  assign last_byte   = (byte_cnt == len_q - 32'd1);
  assign pop         = fifo_rd_vld & (~m_axis_tvalid | m_axis_tready);
  assign drop        = push_q & fifo_full & ~pop;
  // A dropped final word leaves pend_last set; it is replaced by an empty tlast beat.
  assign fifo_wr     = push_q | pend_last;
  assign fifo_wr_dat = push_q ? push_dat_q : {32'h0, 4'h0, 1'b1};
  assign done        = (state == FLUSH) & m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy        = (state != IDLE);

  always_ff @(posedge adc_clk) begin
    if (adc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && sample_len != 32'd0) begin
          accept    = 1'b1;
          state_nxt = SAMPLE;
        end
      end
      SAMPLE:  if (last_byte) state_nxt = FLUSH;
      FLUSH:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte k lands in lane 3 - k%4; a fresh word starts with unused lanes zeroed.
  always_comb begin
    word_nxt = (byte_cnt[1:0] == 2'd0) ? 32'h0 : acc_q;
    case (byte_cnt[1:0])
      2'd0:    word_nxt[31:24] = adc_data;
      2'd1:    word_nxt[23:16] = adc_data;
      2'd2:    word_nxt[15:8]  = adc_data;
      default: word_nxt[7:0]   = adc_data;
    endcase
    keep_nxt = 4'b1111 << (2'd3 - byte_cnt[1:0]);
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      start_q    <= 1'b0;
      len_q      <= 32'd0;
      byte_cnt   <= 32'd0;
      acc_q      <= 32'd0;
      push_q     <= 1'b0;
      push_dat_q <= 37'd0;
      pend_last  <= 1'b0;
      st_clr     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      start_q <= sample_start;
      st_clr  <= accept;
      push_q  <= 1'b0;
      if (accept) begin
        len_q     <= sample_len;
        byte_cnt  <= 32'd0;
        overflow  <= 1'b0;
        pend_last <= 1'b0;
      end
      if (state == SAMPLE) begin
        acc_q    <= word_nxt;
        byte_cnt <= byte_cnt + 32'd1;
        if (byte_cnt[1:0] == 2'd3 || last_byte) begin
          push_q     <= 1'b1;
          push_dat_q <= {word_nxt, keep_nxt, last_byte};
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (push_dat_q[0]) pend_last <= 1'b1;
      end else if (pend_last && !push_q && (!fifo_full || pop)) begin
        pend_last <= 1'b0;
      end
    end
  end

  ad9280_sample_fifo #(
    .DW    (37),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk    (adc_clk),
    .rst    (adc_rst),
    .wr_vld (fifo_wr),
    .wr_dat (fifo_wr_dat),
    .rd_rdy (pop),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full)
  );

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'd0;
      m_axis_tkeep  <= 4'd0;
      m_axis_tlast  <= 1'b0;
    end else if (pop) begin
      m_axis_tvalid <= 1'b1;
      {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= fifo_rd_dat;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ad9280_sample_packer.sv
// Bench for ad9280_sample_packer: table of captures with hand-computed beats, plus overflow, zero-length and mid-capture reset sequences.
// A small FIFO depth is used so that a 40-cycle stall overruns it.

module tb_ad9280_sample_packer;
  logic        adc_clk = 1'b0;
  logic        adc_rst = 1'b1;
  logic [7:0]  adc_data = 8'h00;
  logic        sample_start = 1'b0;
  logic [31:0] sample_len = 32'd0;
  logic        st_clr, busy, done, overflow;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 adc_clk = ~adc_clk;

  ad9280_sample_packer #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .adc_data(adc_data),
    .sample_start(sample_start), .sample_len(sample_len),
    .st_clr(st_clr), .busy(busy), .done(done), .overflow(overflow),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ADC ramp and tready pattern, driven just after each rising edge.
  logic ramp_zero = 1'b0;
  int   rdy_mode = 0;
  int   rdy_cnt = 0;
  initial forever begin
    @(posedge adc_clk);
    #1;
    if (ramp_zero) begin
      adc_data  = 8'h00;
      ramp_zero = 1'b0;
    end else begin
      adc_data = adc_data + 8'h01;
    end
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: begin m_axis_tready = (rdy_cnt >= 40); rdy_cnt++; end
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Beat collector and hold-stability checker.
  logic [31:0] q_dat[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  int          n_stclr = 0, n_done = 0, done_beat = -1;
  logic        hold_q = 1'b0;
  logic [36:0] hold_v = '0;
  always @(negedge adc_clk) begin
    if (adc_rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q)
        check("hold_stable", {26'b0, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
              {26'b0, 1'b1, hold_v});
      if (st_clr) n_stclr++;
      if (m_axis_tvalid && m_axis_tready) begin
        q_dat.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_last.push_back(m_axis_tlast);
        if (done) done_beat = q_dat.size() - 1;
      end
      if (done) n_done++;
      hold_q = m_axis_tvalid & ~m_axis_tready;
      hold_v = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  typedef struct {
    logic [31:0] len;
    int          mode;
    logic        restart;
    int          nb;
    logic [31:0] dat[4];
    logic [3:0]  keep[4];
  } vec_t;
  localparam int NV = 6;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input logic [31:0] len, input int mode, input logic restart,
                         input int nb, input logic [31:0] d0, d1, d2, d3,
                         input logic [3:0] k0, k1, k2, k3);
    vecs[i].len = len; vecs[i].mode = mode; vecs[i].restart = restart; vecs[i].nb = nb;
    vecs[i].dat[0] = d0; vecs[i].dat[1] = d1; vecs[i].dat[2] = d2; vecs[i].dat[3] = d3;
    vecs[i].keep[0] = k0; vecs[i].keep[1] = k1; vecs[i].keep[2] = k2; vecs[i].keep[3] = k3;
  endtask

  task automatic clear_mon();
    q_dat.delete(); q_keep.delete(); q_last.delete();
    n_stclr = 0; n_done = 0; done_beat = -1;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int t = 0;
    while (n_done == 0 && t < limit) begin
      @(negedge adc_clk);
      t++;
    end
    if (n_done == 0) check({nm, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    clear_mon();
    @(negedge adc_clk);
    rdy_mode = vecs[i].mode; rdy_cnt = 0;
    sample_len = vecs[i].len; sample_start = 1'b1; ramp_zero = 1'b1;
    @(negedge adc_clk);
    sample_len = 32'd99;
    if (vecs[i].restart) begin
      @(negedge adc_clk) sample_start = 1'b0;
      @(negedge adc_clk) sample_start = 1'b1;
    end
    wait_done(nm, 400);
    sample_start = 1'b0;
    repeat (3) @(negedge adc_clk);
    check({nm, "_beats"}, q_dat.size(), vecs[i].nb);
    for (int j = 0; j < vecs[i].nb && j < q_dat.size(); j++) begin
      check($sformatf("%s_b%0d_data", nm, j), q_dat[j], vecs[i].dat[j]);
      check($sformatf("%s_b%0d_keep", nm, j), q_keep[j], vecs[i].keep[j]);
      check($sformatf("%s_b%0d_last", nm, j), q_last[j], (j == vecs[i].nb - 1));
    end
    check({nm, "_st_clr"}, n_stclr, 1);
    check({nm, "_done"}, n_done, 1);
    check({nm, "_done_beat"}, done_beat, vecs[i].nb - 1);
    check({nm, "_overflow"}, overflow, 0);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_tvalid_end"}, m_axis_tvalid, 0);
  endtask

  initial begin
    set_vec(0, 32'd8,  0, 1'b0, 2, 32'h00010203, 32'h04050607, 0, 0, 4'hF, 4'hF, 0, 0);
    set_vec(1, 32'd5,  0, 1'b0, 2, 32'h00010203, 32'h04000000, 0, 0, 4'hF, 4'h8, 0, 0);
    set_vec(2, 32'd16, 1, 1'b0, 4, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
            4'hF, 4'hF, 4'hF, 4'hF);
    set_vec(3, 32'd3,  0, 1'b0, 1, 32'h00010200, 0, 0, 0, 4'hE, 0, 0, 0);
    set_vec(4, 32'd6,  1, 1'b1, 2, 32'h00010203, 32'h04050000, 0, 0, 4'hF, 4'hC, 0, 0);
    set_vec(5, 32'd1,  0, 1'b0, 1, 32'h00000000, 0, 0, 0, 4'h8, 0, 0, 0);

    repeat (3) @(negedge adc_clk);
    check("rst_st_clr", st_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    adc_rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Zero-length start is ignored.
    clear_mon();
    @(negedge adc_clk);
    sample_len = 32'd0; sample_start = 1'b1;
    repeat (4) @(negedge adc_clk);
    check("zlen_st_clr", n_stclr, 0);
    check("zlen_busy", busy, 0);
    check("zlen_tvalid", m_axis_tvalid, 0);
    sample_start = 1'b0;
    @(negedge adc_clk);

    // 40-cycle stall overruns the FIFO; tlast must still arrive.
    clear_mon();
    @(negedge adc_clk);
    rdy_mode = 2; rdy_cnt = 0; sample_len = 32'd64; sample_start = 1'b1; ramp_zero = 1'b1;
    wait_done("ovf", 600);
    sample_start = 1'b0;
    repeat (3) @(negedge adc_clk);
    check("ovf_overflow", overflow, 1);
    check("ovf_beats_lt16", (q_dat.size() < 16), 1);
    check("ovf_beats_nonzero", (q_dat.size() > 0), 1);
    if (q_dat.size() > 0) begin
      check("ovf_first_data", q_dat[0], 32'h00010203);
      check("ovf_final_tlast", q_last[q_dat.size()-1], 1);
    end
    check("ovf_done", n_done, 1);
    check("ovf_done_beat", done_beat, q_dat.size() - 1);
    check("ovf_busy_end", busy, 0);

    run_vec(0);

    // Reset while a beat is stalled on the bus.
    clear_mon();
    @(negedge adc_clk);
    rdy_mode = 3; sample_len = 32'd64; sample_start = 1'b1; ramp_zero = 1'b1;
    begin
      int t = 0;
      while (!m_axis_tvalid && t < 100) begin
        @(negedge adc_clk);
        t++;
      end
      check("rstmid_tvalid_seen", m_axis_tvalid, 1);
    end
    repeat (2) @(negedge adc_clk);
    adc_rst = 1'b1; sample_start = 1'b0;
    @(negedge adc_clk);
    check("rstmid_tvalid", m_axis_tvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_tlast", m_axis_tlast, 0);
    check("rstmid_overflow", overflow, 0);
    adc_rst = 1'b0; rdy_mode = 0;
    repeat (2) @(negedge adc_clk);
    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
